ovl_change_multi: RTL and testbench
===================================

# ovl_change_multi

Multi-channel, parametrised change checker for the OVL assertion library. Each channel opens a window on its own `start_event`. The channel's `test_expr` must then change value no earlier than `MIN_CKS` and no later than `NUM_CKS` clocks after the start. Per-channel fire pulses, window status and shared saturating pass/fail counters are provided. Instantiated in testbenches and assertion wrappers alongside `ovl_change`, covering buses of independent handshake channels with one instance.

## Interface
- `CHANNELS`, 4, number of independent channels (>=1)
- `WIDTH`, 8, bits of `test_expr` per channel (>=1)
- `NUM_CKS`, 4, last window cycle in which a change is accepted (>=1)
- `MIN_CKS`, 1, first window cycle in which a change is accepted (1..`NUM_CKS`)
- `ACTION_ON_NEW_START`, 0, start_event inside an open window: 0 ignore, 1 restart, 2 fire and restart
- `CNT_W`, 16, width of the pass/fail counters

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  global checker enable
- `start_event`  in  `CHANNELS`  per-channel window start
- `test_expr`  in  `CHANNELS*WIDTH`  channel c occupies bits [c*WIDTH +: WIDTH]
- `fire_miss`  out  `CHANNELS`  no change by window cycle `NUM_CKS`
- `fire_early`  out  `CHANNELS`  change before window cycle `MIN_CKS`
- `fire_new_start`  out  `CHANNELS`  start_event inside an open window (mode 2 only)
- `window_open`  out  `CHANNELS`  channel is in WINDOW state
- `pass_count`  out  `CNT_W`  windows closed by an in-range change, saturating
- `fail_count`  out  `CNT_W`  total fire events of any kind, saturating

## Operation
- Per-channel FSM with states IDLE and WINDOW, a reference register of `WIDTH` bits, and a cycle counter of width $clog2(`NUM_CKS`+1).
- IDLE to WINDOW: at an edge with `enable`=1 and `start_event[c]`=1.
  - Capture `test_expr[c]` into the reference register.
  - Set the counter to 1.
- In WINDOW, each edge evaluates k = counter and changed = (`test_expr[c]` != reference).
  - changed and k<`MIN_CKS`: pulse `fire_early`, go to IDLE.
  - changed and `MIN_CKS`<=k<=`NUM_CKS`: count a pass, go to IDLE.
  - not changed and k==`NUM_CKS`: pulse `fire_miss`, go to IDLE.
  - otherwise: counter increments, stay in WINDOW.
- `start_event[c]` in WINDOW when the window does not close on that edge:
  - Mode 0: ignored.
  - Mode 1: recapture the reference, counter=1, no fire.
  - Mode 2: same as mode 1, plus pulse `fire_new_start`.
- `start_event[c]` on the edge that closes a window (pass or fire): that window's outcome is reported, and a new window opens on the same edge, capturing the current `test_expr[c]`. This makes back-to-back windows gapless in all modes.
- `enable`=0: every channel is forced to IDLE on the next edge with no fire and no pass. Start events are ignored.
- Counters:
  - `pass_count` adds the number of channels passing on that edge.
  - `fail_count` adds the popcount of all fire bits asserted on that edge.
  - Both saturate at 2^`CNT_W`-1; there is no wrap.
- Channels are fully independent. Simultaneous events on different channels are all reported on the same edge.

## Timing
- Reset (`reset`=0, asynchronous): all FSMs go to IDLE, counters are 0, reference registers are 0, and all outputs are 0. Outputs stay 0 until the first edge after release.
- Reset mid-window aborts the window silently; nothing is counted.
- Start sampled at edge T0 with `window_open` high from T0 on. `test_expr` is compared at edges T1..T`NUM_CKS`.
- All fire outputs are registered. A fire pulse is high for exactly one cycle following the edge at which the condition was detected.
- Counters update on the same edge as the corresponding pass or fire.
- `window_open` drops after the closing edge, unless the same edge reopens the window.
- Maximum detection latency: `NUM_CKS` clocks after the start edge.

## Test plan
- Defaults, ch0: start at T0 with `test_expr`=0x00; change to 0x5A before T2 -> pass at T2, `pass_count`=1, no fire.
- Ch1: start, hold `test_expr` constant -> `fire_miss[1]` one-cycle pulse after T4, `fail_count`=1, `window_open[1]` low after T4.
- `MIN_CKS`=3, `NUM_CKS`=6: change sampled at T1 -> `fire_early` after T1. Change sampled at T3 -> pass. Change sampled at T6 -> pass.
- Mode 2: second start at T2 with no change -> `fire_new_start` after T2. Window restarts, and `fire_miss` follows after T6 (relative to the original T0).
- All 4 channels start together; ch0 and ch2 change at T2, ch1 and ch3 never change -> `pass_count`=2, `fail_count`=2, with simultaneous fires on ch1 and ch3.
- Assert `reset` low at T2 of an open window -> all outputs 0 immediately and no counts. Separately, drop `enable` mid-window -> silent abort, no fire.

Source files
------------

// File: rtl/ovl_change_multi.sv
// Multi-channel change checker: each channel opens a window on start_event and
// expects test_expr to change within window cycles MIN_CKS..NUM_CKS.
`timescale 1ns/1ps
module ovl_change_multi #(
    parameter int unsigned CHANNELS            = 4,
    parameter int unsigned WIDTH               = 8,
    parameter int unsigned NUM_CKS             = 4,
    parameter int unsigned MIN_CKS             = 1,
    parameter int unsigned ACTION_ON_NEW_START = 0,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       start_event,
    input  logic [CHANNELS*WIDTH-1:0] test_expr,
    output logic [CHANNELS-1:0]       fire_miss,
    output logic [CHANNELS-1:0]       fire_early,
    output logic [CHANNELS-1:0]       fire_new_start,
    output logic [CHANNELS-1:0]       window_open,
    output logic [CNT_W-1:0]          pass_count,
    output logic [CNT_W-1:0]          fail_count
);

    localparam int unsigned CW    = $clog2(NUM_CKS + 1);
    localparam int unsigned INC_W = $clog2(3 * CHANNELS + 1);
    localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    typedef enum logic {IDLE, WINDOW} state_t;

    state_t           state_q [CHANNELS];
    state_t           state_d [CHANNELS];
    logic [WIDTH-1:0] ref_q   [CHANNELS];
    logic [WIDTH-1:0] ref_d   [CHANNELS];
    logic [CW-1:0]    cnt_q   [CHANNELS];
    logic [CW-1:0]    cnt_d   [CHANNELS];

    logic [CHANNELS-1:0] miss_d, early_d, new_start_d, pass_d, close_d, open_d;
    logic [INC_W-1:0]    pass_inc, fail_inc;
    logic [SUM_W-1:0]    pass_sum, fail_sum;
    logic [CNT_W-1:0]    pass_next, fail_next;

    always_comb begin
        miss_d      = '0;
        early_d     = '0;
        new_start_d = '0;
        pass_d      = '0;
        close_d     = '0;
        open_d      = '0;
        pass_inc    = '0;
        fail_inc    = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            ref_d[c]   = ref_q[c];
            cnt_d[c]   = cnt_q[c];
            if (!enable) begin
                state_d[c] = IDLE;
            end else if (state_q[c] == WINDOW) begin
                if (test_expr[c*WIDTH +: WIDTH] != ref_q[c]) begin
                    if (int'(cnt_q[c]) < int'(MIN_CKS))
                        early_d[c] = 1'b1;
                    else
                        pass_d[c] = 1'b1;
                    close_d[c] = 1'b1;
                end else if (int'(cnt_q[c]) == int'(NUM_CKS)) begin
                    miss_d[c]  = 1'b1;
                    close_d[c] = 1'b1;
                end

                if (close_d[c]) begin
                    state_d[c] = IDLE;
                end else if (start_event[c] && (ACTION_ON_NEW_START != 0)) begin
                    ref_d[c]          = test_expr[c*WIDTH +: WIDTH];
                    cnt_d[c]          = CW'(1);
                    new_start_d[c]    = (ACTION_ON_NEW_START == 2);
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end

            // A start on a closing edge reopens immediately, so windows chain without a gap.
            if (enable && start_event[c] && (state_d[c] == IDLE)) begin
                state_d[c] = WINDOW;
                ref_d[c]   = test_expr[c*WIDTH +: WIDTH];
                cnt_d[c]   = CW'(1);
            end

            open_d[c] = (state_d[c] == WINDOW);
            pass_inc  = pass_inc + INC_W'(pass_d[c]);
            fail_inc  = fail_inc + INC_W'(miss_d[c]) + INC_W'(early_d[c])
                                 + INC_W'(new_start_d[c]);
        end

        pass_sum  = SUM_W'(pass_count) + SUM_W'(pass_inc);
        fail_sum  = SUM_W'(fail_count) + SUM_W'(fail_inc);
        pass_next = (|pass_sum[SUM_W-1:CNT_W]) ? '1 : pass_sum[CNT_W-1:0];
        fail_next = (|fail_sum[SUM_W-1:CNT_W]) ? '1 : fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                ref_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
            fire_miss      <= '0;
            fire_early     <= '0;
            fire_new_start <= '0;
            window_open    <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                ref_q[c]   <= ref_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            fire_miss      <= miss_d;
            fire_early     <= early_d;
            fire_new_start <= new_start_d;
            window_open    <= open_d;
            pass_count     <= pass_next;
            fail_count     <= fail_next;
        end
    end

endmodule

// File: tb/tb_ovl_change_multi.sv
// Bench for ovl_change_multi: four differently parameterised instances share stimulus;
// directed scenarios plus a randomized run against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_ovl_change_multi;

    localparam int NI = 4;
    localparam int MINS  [NI] = '{1, 3, 1, 2};
    localparam int NUMS  [NI] = '{4, 6, 4, 5};
    localparam int MODES [NI] = '{0, 0, 2, 1};
    localparam int CMAX  [NI] = '{65535, 65535, 15, 65535};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  start_event = '0;
    logic [31:0] test_expr = '0;

    logic [3:0]  o_wo [NI];
    logic [3:0]  o_fm [NI];
    logic [3:0]  o_fe [NI];
    logic [3:0]  o_fn [NI];
    logic [15:0] pc_a, fc_a, pc_b, fc_b, pc_d, fc_d;
    logic [3:0]  pc_c, fc_c;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ovl_change_multi #(.CHANNELS(4), .WIDTH(8), .NUM_CKS(4), .MIN_CKS(1),
                       .ACTION_ON_NEW_START(0), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .fire_miss(o_fm[0]), .fire_early(o_fe[0]),
        .fire_new_start(o_fn[0]), .window_open(o_wo[0]), .pass_count(pc_a), .fail_count(fc_a));

    ovl_change_multi #(.CHANNELS(4), .WIDTH(8), .NUM_CKS(6), .MIN_CKS(3),
                       .ACTION_ON_NEW_START(0), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .fire_miss(o_fm[1]), .fire_early(o_fe[1]),
        .fire_new_start(o_fn[1]), .window_open(o_wo[1]), .pass_count(pc_b), .fail_count(fc_b));

    ovl_change_multi #(.CHANNELS(4), .WIDTH(8), .NUM_CKS(4), .MIN_CKS(1),
                       .ACTION_ON_NEW_START(2), .CNT_W(4)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .fire_miss(o_fm[2]), .fire_early(o_fe[2]),
        .fire_new_start(o_fn[2]), .window_open(o_wo[2]), .pass_count(pc_c), .fail_count(fc_c));

    ovl_change_multi #(.CHANNELS(4), .WIDTH(8), .NUM_CKS(5), .MIN_CKS(2),
                       .ACTION_ON_NEW_START(1), .CNT_W(16)) u_d (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .fire_miss(o_fm[3]), .fire_early(o_fe[3]),
        .fire_new_start(o_fn[3]), .window_open(o_wo[3]), .pass_count(pc_d), .fail_count(fc_d));

    function automatic logic [15:0] pcnt(input int i);
        case (i)
            0:       return pc_a;
            1:       return pc_b;
            2:       return {12'd0, pc_c};
            default: return pc_d;
        endcase
    endfunction

    function automatic logic [15:0] fcnt(input int i);
        case (i)
            0:       return fc_a;
            1:       return fc_b;
            2:       return {12'd0, fc_c};
            default: return fc_d;
        endcase
    endfunction

    // Reference model: a window is its start cycle plus captured value; age is cycles since start.
    bit          m_open [NI][4];
    int          m_t    [NI][4];
    logic [7:0]  m_ref  [NI][4];
    logic [3:0]  e_wo [NI], e_fm [NI], e_fe [NI], e_fn [NI];
    int          e_pc [NI], e_fc [NI];
    int          cyc;

    task automatic model_clear();
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            e_wo[i] = '0; e_fm[i] = '0; e_fe[i] = '0; e_fn[i] = '0;
            e_pc[i] = 0;  e_fc[i] = 0;
            for (int c = 0; c < 4; c++) begin
                m_open[i][c] = 1'b0; m_t[i][c] = 0; m_ref[i][c] = '0;
            end
        end
    endtask

    task automatic model_edge();
        logic [7:0] v;
        int age, np, nf;
        bit done;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            np = 0;
            e_fm[i] = '0; e_fe[i] = '0; e_fn[i] = '0;
            for (int c = 0; c < 4; c++) begin
                v = test_expr[c*8 +: 8];
                if (!enable) begin
                    m_open[i][c] = 1'b0;
                end else begin
                    if (m_open[i][c]) begin
                        age  = cyc - m_t[i][c];
                        done = 1'b0;
                        if (v != m_ref[i][c]) begin
                            done = 1'b1;
                            if (age < MINS[i]) e_fe[i][c] = 1'b1;
                            else np++;
                        end else if (age == NUMS[i]) begin
                            done = 1'b1;
                            e_fm[i][c] = 1'b1;
                        end
                        if (done) m_open[i][c] = 1'b0;
                        else if (start_event[c] && MODES[i] != 0) begin
                            m_t[i][c] = cyc; m_ref[i][c] = v;
                            if (MODES[i] == 2) e_fn[i][c] = 1'b1;
                        end
                    end
                    if (!m_open[i][c] && start_event[c]) begin
                        m_open[i][c] = 1'b1; m_t[i][c] = cyc; m_ref[i][c] = v;
                    end
                end
                e_wo[i][c] = m_open[i][c];
            end
            nf = $countones(e_fm[i]) + $countones(e_fe[i]) + $countones(e_fn[i]);
            e_pc[i] = (e_pc[i] + np > CMAX[i]) ? CMAX[i] : e_pc[i] + np;
            e_fc[i] = (e_fc[i] + nf > CMAX[i]) ? CMAX[i] : e_fc[i] + nf;
        end
    endtask

    task automatic step(input logic [3:0] st, input logic [31:0] te, input logic en);
        start_event = st;
        test_expr   = te;
        enable      = en;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b0; enable = 1'b0; start_event = '0; test_expr = '0;
        repeat (2) @(negedge clock);
        model_clear();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        enable = 1'b1; start_event = 4'hF;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ((o_wo[i] | o_fm[i] | o_fe[i] | o_fn[i]) !== 4'b0000) begin
                n_bad++; $display("FAIL reset_flags inst%0d: got %b required 0000", i, o_wo[i] | o_fm[i] | o_fe[i] | o_fn[i]);
            end
            n_vec++;
            if ((pcnt(i) | fcnt(i)) !== 16'd0) begin
                n_bad++; $display("FAIL reset_counts inst%0d: got %h/%h required 0/0", i, pcnt(i), fcnt(i));
            end
        end
        repeat (2) @(negedge clock);
        n_vec++;
        if (o_wo[0] !== 4'b0000) begin
            n_bad++; $display("FAIL reset_hold: window_open %b required 0000", o_wo[0]);
        end
        apply_reset();
    endtask

    task automatic test_pass_window();
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        n_vec++;
        if (o_wo[0] !== 4'b0001) begin n_bad++; $display("FAIL pass_open: got %b required 0001", o_wo[0]); end
        step(4'b0000, 32'h0, 1'b1);
        n_vec++;
        if (pcnt(0) !== 16'd0) begin n_bad++; $display("FAIL pass_t1_count: got %0d required 0", pcnt(0)); end
        step(4'b0000, 32'h5A, 1'b1);
        n_vec++;
        if (pcnt(0) !== 16'd1) begin n_bad++; $display("FAIL pass_count: got %0d required 1", pcnt(0)); end
        n_vec++;
        if ((o_wo[0] | o_fm[0] | o_fe[0] | o_fn[0] | fcnt(0)[3:0]) !== 4'b0000) begin
            n_bad++; $display("FAIL pass_quiet: got %b required 0000", o_wo[0] | o_fm[0] | o_fe[0] | o_fn[0] | fcnt(0)[3:0]);
        end
    endtask

    task automatic test_miss();
        apply_reset();
        step(4'b0010, 32'h33333333, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step(4'b0000, 32'h33333333, 1'b1);
            n_vec++;
            if ({o_fm[0], o_wo[0]} !== 8'b0000_0010) begin
                n_bad++; $display("FAIL miss_pending T%0d: fm/wo %b required 00000010", k, {o_fm[0], o_wo[0]});
            end
        end
        step(4'b0000, 32'h33333333, 1'b1);
        n_vec++;
        if (o_fm[0] !== 4'b0010) begin n_bad++; $display("FAIL miss_fire: got %b required 0010", o_fm[0]); end
        n_vec++;
        if (fcnt(0) !== 16'd1) begin n_bad++; $display("FAIL miss_count: got %0d required 1", fcnt(0)); end
        n_vec++;
        if (o_wo[0] !== 4'b0000) begin n_bad++; $display("FAIL miss_closed: got %b required 0000", o_wo[0]); end
        step(4'b0000, 32'h33333333, 1'b1);
        n_vec++;
        if (o_fm[0] !== 4'b0000) begin n_bad++; $display("FAIL miss_pulse_width: got %b required 0000", o_fm[0]); end
    endtask

    task automatic test_min_window();
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        step(4'b0000, 32'h1, 1'b1);
        n_vec++;
        if (o_fe[1] !== 4'b0001 || fcnt(1) !== 16'd1) begin
            n_bad++; $display("FAIL early_t1: fe %b cnt %0d required 0001 1", o_fe[1], fcnt(1));
        end
        step(4'b0001, 32'h1, 1'b1);
        step(4'b0000, 32'h1, 1'b1);
        step(4'b0000, 32'h2, 1'b1);
        n_vec++;
        if (o_fe[1] !== 4'b0001 || fcnt(1) !== 16'd2) begin
            n_bad++; $display("FAIL early_t2: fe %b cnt %0d required 0001 2", o_fe[1], fcnt(1));
        end
        step(4'b0001, 32'h2, 1'b1);
        step(4'b0000, 32'h2, 1'b1);
        step(4'b0000, 32'h2, 1'b1);
        step(4'b0000, 32'h3, 1'b1);
        n_vec++;
        if (pcnt(1) !== 16'd1 || o_fe[1] !== 4'b0000) begin
            n_bad++; $display("FAIL pass_t3: cnt %0d fe %b required 1 0000", pcnt(1), o_fe[1]);
        end
        step(4'b0001, 32'h3, 1'b1);
        for (int k = 1; k <= 5; k++) step(4'b0000, 32'h3, 1'b1);
        n_vec++;
        if (o_wo[1] !== 4'b0001) begin n_bad++; $display("FAIL open_t5: got %b required 0001", o_wo[1]); end
        step(4'b0000, 32'h4, 1'b1);
        n_vec++;
        if (pcnt(1) !== 16'd2 || o_wo[1] !== 4'b0000 || o_fm[1] !== 4'b0000) begin
            n_bad++; $display("FAIL pass_t6: cnt %0d wo %b fm %b required 2 0000 0000", pcnt(1), o_wo[1], o_fm[1]);
        end
    endtask

    task automatic test_new_start();
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0001, 32'h0, 1'b1);
        n_vec++;
        if (o_fn[2] !== 4'b0001 || o_wo[2] !== 4'b0001 || fcnt(2) !== 16'd1) begin
            n_bad++; $display("FAIL new_start_fire: fn %b wo %b cnt %0d required 0001 0001 1", o_fn[2], o_wo[2], fcnt(2));
        end
        for (int k = 3; k <= 5; k++) begin
            step(4'b0000, 32'h0, 1'b1);
            n_vec++;
            if ((o_fm[2] | o_fn[2]) !== 4'b0000) begin
                n_bad++; $display("FAIL new_start_quiet T%0d: got %b required 0000", k, o_fm[2] | o_fn[2]);
            end
        end
        step(4'b0000, 32'h0, 1'b1);
        n_vec++;
        if (o_fm[2] !== 4'b0001 || fcnt(2) !== 16'd2 || o_wo[2] !== 4'b0000) begin
            n_bad++; $display("FAIL new_start_miss: fm %b cnt %0d wo %b required 0001 2 0000", o_fm[2], fcnt(2), o_wo[2]);
        end
    endtask

    task automatic test_restart();
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0001, 32'h0, 1'b1);
        n_vec++;
        if (o_fn[3] !== 4'b0000 || o_wo[3] !== 4'b0001) begin
            n_bad++; $display("FAIL restart_silent: fn %b wo %b required 0000 0001", o_fn[3], o_wo[3]);
        end
        for (int k = 3; k <= 6; k++) step(4'b0000, 32'h0, 1'b1);
        n_vec++;
        if (o_fm[3] !== 4'b0000) begin n_bad++; $display("FAIL restart_early_miss: got %b required 0000", o_fm[3]); end
        step(4'b0000, 32'h0, 1'b1);
        n_vec++;
        if (o_fm[3] !== 4'b0001 || fcnt(3) !== 16'd1) begin
            n_bad++; $display("FAIL restart_miss: fm %b cnt %0d required 0001 1", o_fm[3], fcnt(3));
        end
    endtask

    task automatic test_all_channels();
        apply_reset();
        step(4'b1111, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0000, 32'h00220011, 1'b1);
        n_vec++;
        if (pcnt(0) !== 16'd2 || o_wo[0] !== 4'b1010) begin
            n_bad++; $display("FAIL multi_pass: cnt %0d wo %b required 2 1010", pcnt(0), o_wo[0]);
        end
        step(4'b0000, 32'h00220011, 1'b1);
        step(4'b0000, 32'h00220011, 1'b1);
        n_vec++;
        if (o_fm[0] !== 4'b1010 || fcnt(0) !== 16'd2 || o_wo[0] !== 4'b0000) begin
            n_bad++; $display("FAIL multi_miss: fm %b cnt %0d wo %b required 1010 2 0000", o_fm[0], fcnt(0), o_wo[0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0001, 32'h7, 1'b1);
        n_vec++;
        if (pcnt(0) !== 16'd1 || o_wo[0] !== 4'b0001) begin
            n_bad++; $display("FAIL b2b_reopen: cnt %0d wo %b required 1 0001", pcnt(0), o_wo[0]);
        end
        for (int k = 1; k <= 3; k++) step(4'b0000, 32'h7, 1'b1);
        n_vec++;
        if (o_fm[0] !== 4'b0000 || o_wo[0] !== 4'b0001) begin
            n_bad++; $display("FAIL b2b_hold: fm %b wo %b required 0000 0001", o_fm[0], o_wo[0]);
        end
        step(4'b0000, 32'h7, 1'b1);
        n_vec++;
        if (o_fm[0] !== 4'b0001 || fcnt(0) !== 16'd1) begin
            n_bad++; $display("FAIL b2b_miss: fm %b cnt %0d required 0001 1", o_fm[0], fcnt(0));
        end
    endtask

    task automatic test_abort();
        apply_reset();
        step(4'b0011, 32'h0, 1'b1);
        step(4'b0000, 32'h100, 1'b1);
        n_vec++;
        if (o_fe[1] !== 4'b0010 || fcnt(1) !== 16'd1 || o_wo[1] !== 4'b0001) begin
            n_bad++; $display("FAIL abort_setup: fe %b cnt %0d wo %b required 0010 1 0001", o_fe[1], fcnt(1), o_wo[1]);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ((o_wo[1] | o_fe[1] | o_fm[1]) !== 4'b0000 || fcnt(1) !== 16'd0) begin
            n_bad++; $display("FAIL abort_reset: flags %b cnt %0d required 0000 0", o_wo[1] | o_fe[1] | o_fm[1], fcnt(1));
        end
        #1;
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 7; k++) begin
            step(4'b0000, 32'h100, 1'b1);
            n_vec++;
            if ((o_wo[1] | o_fm[1] | o_fe[1]) !== 4'b0000 || fcnt(1) !== 16'd0 || pcnt(1) !== 16'd0) begin
                n_bad++; $display("FAIL abort_silent c%0d: flags %b cnt %0d/%0d required 0000 0/0", k, o_wo[1] | o_fm[1] | o_fe[1], pcnt(1), fcnt(1));
            end
        end
        apply_reset();
        step(4'b0001, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0001, 32'h0, 1'b0);
        n_vec++;
        if (o_wo[0] !== 4'b0000) begin n_bad++; $display("FAIL enable_abort: wo %b required 0000", o_wo[0]); end
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 32'h0, 1'b1);
            n_vec++;
            if ((o_fm[0] | o_wo[0]) !== 4'b0000 || fcnt(0) !== 16'd0) begin
                n_bad++; $display("FAIL enable_silent c%0d: flags %b cnt %0d required 0000 0", k, o_fm[0] | o_wo[0], fcnt(0));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  st;
        logic [31:0] te;
        logic        en;
        apply_reset();
        te = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 4; c++) begin
                st[c] = ($urandom_range(3) == 0);
                if ($urandom_range(4) == 0) te[c*8 +: 8] = 8'($urandom_range(255));
            end
            en = ($urandom_range(63) != 0);
            step(st, te, en);
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if ({o_wo[i], o_fm[i], o_fe[i], o_fn[i]} !== {e_wo[i], e_fm[i], e_fe[i], e_fn[i]}) begin
                    n_bad++; $display("FAIL rand_flags inst%0d cyc%0d: wo/fm/fe/fn %b required %b", i, n,
                                      {o_wo[i], o_fm[i], o_fe[i], o_fn[i]}, {e_wo[i], e_fm[i], e_fe[i], e_fn[i]});
                end
                n_vec++;
                if (pcnt(i) !== 16'(e_pc[i]) || fcnt(i) !== 16'(e_fc[i])) begin
                    n_bad++; $display("FAIL rand_counts inst%0d cyc%0d: pass/fail %0d/%0d required %0d/%0d", i, n,
                                      pcnt(i), fcnt(i), e_pc[i], e_fc[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        test_reset();
        test_pass_window();
        test_miss();
        test_min_window();
        test_new_start();
        test_restart();
        test_all_channels();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
